// File: rtl/i2c_reg_responder_pkg.sv
// Shared definitions for the I2C register responder: FSM states and bus bit meanings.
package i2c_reg_responder_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_A,
        ST_SUB,
        ST_ACK_S,
        ST_WR,
        ST_ACK_W,
        ST_RD,
        ST_MACK,
        ST_WAIT_P
    } state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic [6:0] DEF_DEV_ADDR = 7'h39;

endpackage

// File: rtl/i2c_reg_responder_line_filter.sv
// Two-flop synchronizer plus stability filter for one I2C line; emits the filtered
// level and single-cycle rise/fall pulses aligned with the level change.
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic                sync1_reg;
    logic                sync2_reg;
    logic [FILT_LEN-1:0] hist_reg;
    logic                level_reg;
    logic                rise_reg;
    logic                fall_reg;

    // Idle bus is pulled up, so everything resets to the high level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            hist_reg  <= '1;
            level_reg <= 1'b1;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            sync1_reg <= line;
            sync2_reg <= sync1_reg;
            hist_reg  <= {hist_reg[FILT_LEN-2:0], sync2_reg};
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            if ((&hist_reg) && !level_reg) begin
                level_reg <= 1'b1;
                rise_reg  <= 1'b1;
            end else if (!(|hist_reg) && level_reg) begin
                level_reg <= 1'b0;
                fall_reg  <= 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/i2c_reg_responder.sv
// I2C target with a byte-addressed register file, oversampled SCL/SDA, open-drain SDA
// via a drive-low enable, and a combinational local peek port.
module i2c_reg_responder
    import i2c_reg_responder_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = DEF_DEV_ADDR,
    parameter int         REG_DEPTH = 256,
    parameter int         FILT_LEN  = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_drive_low,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    input  logic [7:0] reg_rd_addr,
    output logic [7:0] reg_rd_data
);

    localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filter (
        .clock(clock), .reset(reset), .line(scl_in),
        .level(scl_level), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filter (
        .clock(clock), .reset(reset), .line(sda_in),
        .level(sda_level), .rise(sda_rise), .fall(sda_fall)
    );

    state_t         state_reg, state_next;
    logic [2:0]     bit_cnt_reg, bit_cnt_next;
    logic [7:0]     shift_reg, shift_next;
    logic [AW-1:0]  ptr_reg, ptr_next;
    logic           phase_reg, phase_next;
    logic           rw_reg, rw_next;
    logic           drive_reg, drive_next;
    logic           busy_reg, busy_next;
    logic           strobe_reg, strobe_next;
    logic [7:0]     wr_addr_reg, wr_addr_next;
    logic [7:0]     wr_data_reg, wr_data_next;
    logic           mem_we;
    logic [7:0]     mem_reg [REG_DEPTH];
    logic [7:0]     mem_at_ptr;
    logic [7:0]     byte_in;
    logic           start_det, stop_det, last_bit;

    assign byte_in    = {shift_reg[6:0], sda_level};
    assign start_det  = sda_fall & scl_level;
    assign stop_det   = sda_rise & scl_level;
    assign last_bit   = (bit_cnt_reg == 3'd7);
    assign mem_at_ptr = mem_reg[ptr_reg];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // phase_reg marks the second half of an ACK/MACK slot, or the 8th bit sent in RD.
    always_comb begin
        state_next = state_reg;
        if (start_det) begin
            state_next = ST_ADDR;
        end else if (stop_det) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_ADDR: if (scl_rise && last_bit)
                             state_next = (byte_in[7:1] == DEV_ADDR) ? ST_ACK_A : ST_IDLE;
                ST_SUB:  if (scl_rise && last_bit) state_next = ST_ACK_S;
                ST_WR:   if (scl_rise && last_bit) state_next = ST_ACK_W;
                ST_ACK_A: if (scl_fall && phase_reg) state_next = rw_reg ? ST_RD : ST_SUB;
                ST_ACK_S, ST_ACK_W: if (scl_fall && phase_reg) state_next = ST_WR;
                ST_RD:   if (scl_fall && phase_reg) state_next = ST_MACK;
                ST_MACK: begin
                    if (scl_rise && (sda_level == I2C_NACK)) state_next = ST_WAIT_P;
                    else if (scl_fall && phase_reg)          state_next = ST_RD;
                end
                default: state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        ptr_next     = ptr_reg;
        phase_next   = phase_reg;
        rw_next      = rw_reg;
        drive_next   = drive_reg;
        busy_next    = busy_reg;
        strobe_next  = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;
        mem_we       = 1'b0;
        if (start_det || stop_det) begin
            bit_cnt_next = 3'd0;
            phase_next   = 1'b0;
            drive_next   = 1'b0;
            busy_next    = start_det;
        end else begin
            case (state_reg)
                ST_ADDR, ST_SUB, ST_WR: if (scl_rise) begin
                    shift_next   = byte_in;
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    phase_next   = 1'b0;
                    if (last_bit) begin
                        if (state_reg == ST_ADDR) rw_next = byte_in[0];
                        if (state_reg == ST_SUB)  ptr_next = byte_in[AW-1:0];
                        if (state_reg == ST_WR) begin
                            mem_we       = 1'b1;
                            strobe_next  = 1'b1;
                            wr_addr_next = 8'(ptr_reg);
                            wr_data_next = byte_in;
                            ptr_next     = ptr_reg + AW'(1);
                        end
                    end
                end
                ST_ACK_A, ST_ACK_S, ST_ACK_W: if (scl_fall) begin
                    phase_next   = !phase_reg;
                    drive_next   = !phase_reg;
                    bit_cnt_next = 3'd0;
                    if (phase_reg && state_reg == ST_ACK_A && rw_reg) begin
                        shift_next = mem_at_ptr;
                        drive_next = !mem_at_ptr[7];
                    end
                end
                ST_RD: begin
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (last_bit) phase_next = 1'b1;
                    end else if (scl_fall) begin
                        if (phase_reg) begin
                            drive_next   = 1'b0;
                            phase_next   = 1'b0;
                            bit_cnt_next = 3'd0;
                        end else begin
                            shift_next = {shift_reg[6:0], 1'b0};
                            drive_next = !shift_reg[6];
                        end
                    end
                end
                ST_MACK: begin
                    if (scl_rise && (sda_level == I2C_ACK)) begin
                        ptr_next   = ptr_reg + AW'(1);
                        phase_next = 1'b1;
                    end else if (scl_fall && phase_reg) begin
                        shift_next   = mem_at_ptr;
                        drive_next   = !mem_at_ptr[7];
                        phase_next   = 1'b0;
                        bit_cnt_next = 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt_reg <= 3'd0;
            shift_reg   <= 8'h00;
            ptr_reg     <= '0;
            phase_reg   <= 1'b0;
            rw_reg      <= 1'b0;
            drive_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            strobe_reg  <= 1'b0;
            wr_addr_reg <= 8'h00;
            wr_data_reg <= 8'h00;
        end else begin
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            ptr_reg     <= ptr_next;
            phase_reg   <= phase_next;
            rw_reg      <= rw_next;
            drive_reg   <= drive_next;
            busy_reg    <= busy_next;
            strobe_reg  <= strobe_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
        end
    end

    generate
        for (genvar gi = 0; gi < REG_DEPTH; gi++) begin : g_reg
            always_ff @(posedge clock or posedge reset) begin
                if (reset)                               mem_reg[gi] <= 8'h00;
                else if (mem_we && ptr_reg == AW'(gi))   mem_reg[gi] <= byte_in;
            end
        end
    endgenerate

    assign reg_rd_data   = mem_reg[reg_rd_addr[AW-1:0]];
    assign sda_drive_low = drive_reg;
    assign wr_strobe     = strobe_reg;
    assign wr_addr       = wr_addr_reg;
    assign wr_data       = wr_data_reg;
    assign busy          = busy_reg;

endmodule
